// File: rtl/ndma_pkg.sv
// NanoDMA shared definitions.
//   ndma_rd_state_e : source read engine FSM states.
//   ndma_align      : byte stride and address alignment mask for a given data width.
package ndma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StFinish
  } ndma_rd_state_e;

  typedef struct packed {
    logic [63:0] stride;
    logic [63:0] mask;
  } ndma_align_t;

  // Bytes per word and the mask that clears the sub-word address bits.
  function automatic ndma_align_t ndma_align(input int unsigned data_width);
    ndma_align_t a;
    a.stride = 64'(data_width / 8);
    a.mask   = ~(a.stride - 64'd1);
    return a;
  endfunction

endpackage

// File: rtl/ndma_src_reader.sv
// NanoDMA source-side read engine.
// On an accepted start it issues word-aligned OBI reads from the source address and pushes
// every returned word straight into the DMA data FIFO. New requests are only raised while the
// number of granted-but-unanswered reads is below both MaxOutstanding and the FIFO free space,
// so returned data can never overflow the FIFO.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   start_i                one-cycle start command (ignored unless idle)
//   src_addr_i, len_i      source byte address and length in words, sampled on start
//   busy_o, done_o, err_o  status: busy span, one-cycle completion pulse, sticky response error
//   obi_*                  OBI read master (A and R channels)
//   fifo_free_i            free slots of the downstream FIFO
//   fifo_push_o, fifo_data_o  FIFO push strobe and data
module ndma_src_reader
  import ndma_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxTxSize      = 256,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned LenW           = $clog2(MaxTxSize) + 1,
  parameter int unsigned FreeW          = $clog2(FifoDepth) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   src_addr_i,
  input  logic [LenW-1:0]        len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  input  logic                   obi_rvalid_i,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic                   obi_err_i,
  input  logic [FreeW-1:0]       fifo_free_i,
  output logic                   fifo_push_o,
  output logic [DataWidth-1:0]   fifo_data_o
);

  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam ndma_align_t Align = ndma_align(DataWidth);
  localparam logic [AddrWidth-1:0] Stride    = Align.stride[AddrWidth-1:0];
  localparam logic [AddrWidth-1:0] AlignMask = Align.mask[AddrWidth-1:0];

  ndma_rd_state_e       state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [LenW-1:0]      remaining_q;
  logic [OutW-1:0]      outstanding_q;
  logic                 hold_q;   // request raised but not yet granted
  logic                 done_q;
  logic                 err_q;

  logic credit_ok;
  logic req;
  logic grant;

  // Credit is only consulted when raising; once raised, hold_q keeps the request up until
  // granted no matter how the credit inputs move.
  assign credit_ok = (32'(outstanding_q) < MaxOutstanding) &&
                     (32'(outstanding_q) < 32'(fifo_free_i));
  assign req       = hold_q | ((state_q == StIssue) && (remaining_q != '0) && credit_ok);
  assign grant     = req & obi_gnt_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remaining_q   <= '0;
      outstanding_q <= '0;
      hold_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // A grant and a response in the same cycle cancel out.
      case ({grant, obi_rvalid_i})
        2'b10:   outstanding_q <= outstanding_q + OutW'(1);
        2'b01:   outstanding_q <= outstanding_q - OutW'(1);
        default: outstanding_q <= outstanding_q;
      endcase

      // Errored responses still land in the FIFO; only the sticky flag records them.
      if (obi_rvalid_i && obi_err_i) begin
        err_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (start_i) begin
            err_q <= 1'b0;
            if (len_i == '0) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              addr_q      <= src_addr_i & AlignMask;
              remaining_q <= len_i;
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          if (grant) begin
            addr_q      <= addr_q + Stride;
            remaining_q <= remaining_q - LenW'(1);
            hold_q      <= 1'b0;
            if (remaining_q == LenW'(1)) begin
              state_q <= StDrain;
            end
          end else if (req) begin
            hold_q <= 1'b1;
          end
        end
        StDrain: begin
          // A response in this cycle means the counter is not really settled yet.
          if ((outstanding_q == '0) && !obi_rvalid_i) begin
            state_q <= StFinish;
            done_q  <= 1'b1;
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign obi_req_o   = req;
  assign obi_addr_o  = addr_q;
  assign obi_we_o    = 1'b0;
  assign obi_be_o    = '1;
  assign fifo_push_o = obi_rvalid_i;
  assign fifo_data_o = obi_rdata_i;

endmodule

// File: tb/tb_ndma_src_reader.sv
module tb_ndma_src_reader;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned MTS   = 256;
  localparam int unsigned MO    = 2;
  localparam int unsigned FD    = 4;
  localparam int unsigned LenW  = 9;
  localparam int unsigned FreeW = 3;

  logic             clk;
  logic             rst_i;
  logic             start_i;
  logic [AW-1:0]    src_addr_i;
  logic [LenW-1:0]  len_i;
  logic             busy_o, done_o, err_o;
  logic             obi_req_o, obi_gnt_i;
  logic [AW-1:0]    obi_addr_o;
  logic             obi_we_o;
  logic [DW/8-1:0]  obi_be_o;
  logic             obi_rvalid_i;
  logic [DW-1:0]    obi_rdata_i;
  logic             obi_err_i;
  logic [FreeW-1:0] fifo_free_i;
  logic             fifo_push_o;
  logic [DW-1:0]    fifo_data_o;

  ndma_src_reader #(
    .DataWidth     (DW),
    .AddrWidth     (AW),
    .MaxTxSize     (MTS),
    .MaxOutstanding(MO),
    .FifoDepth     (FD),
    .LenW          (LenW),
    .FreeW         (FreeW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .src_addr_i  (src_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .obi_req_o   (obi_req_o),
    .obi_gnt_i   (obi_gnt_i),
    .obi_addr_o  (obi_addr_o),
    .obi_we_o    (obi_we_o),
    .obi_be_o    (obi_be_o),
    .obi_rvalid_i(obi_rvalid_i),
    .obi_rdata_i (obi_rdata_i),
    .obi_err_i   (obi_err_i),
    .fifo_free_i (fifo_free_i),
    .fifo_push_o (fifo_push_o),
    .fifo_data_o (fifo_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Slave policy, set by the directed sequence while the engine is idle.
  int gnt_wait  = 0;
  int rsp_lat   = 1;
  int err_idx   = -1;
  int out_limit = MO;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  rsp_t rsp_q[$];
  int   rsp_idx = 0;

  // Shared between the negedge model/checker and the posedge slave driver.
  int          ncyc = 0;
  bit          hs_valid = 0;
  logic [31:0] hs_addr;
  int          hs_cyc;
  int          held_cnt = 0;

  // Reference model of the transfer.
  bit          m_busy = 0;
  bit          m_err = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          rsp_left = 0;
  int          done_due = -1;
  int          m_out = 0;
  bit          held = 0;
  logic [31:0] held_addr;

  // Per-transfer statistics for the literal checks.
  int          n_push = 0, n_done = 0, n_req_cycles = 0, max_held = 0;
  int          start_cyc = 0, done_cyc = 0;
  logic [31:0] first_addr = '0;
  bit          first_seen = 0;

  // OBI slave: grant after gnt_wait stalled cycles, answer rsp_lat cycles after the grant.
  initial begin
    rsp_t r;
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_rdata_i  = '0;
    obi_err_i    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_i) begin
        rsp_q.delete();
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        obi_err_i    = 1'b0;
      end else begin
        if (hs_valid) rsp_q.push_back('{hs_addr, hs_cyc + rsp_lat});
        obi_gnt_i = (held_cnt >= gnt_wait);
        if (rsp_q.size() != 0 && rsp_q[0].due <= ncyc + 1) begin
          r = rsp_q.pop_front();
          obi_rvalid_i = 1'b1;
          obi_rdata_i  = pattern(r.addr);
          obi_err_i    = (rsp_idx == err_idx);
          rsp_idx++;
        end else begin
          obi_rvalid_i = 1'b0;
          obi_rdata_i  = $urandom;
          obi_err_i    = 1'b0;
        end
      end
    end
  end

  // Model and compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    bit          exp_req;
    logic [31:0] exp_v;
    ncyc++;
    hs_valid = 0;
    if (rst_i) begin
      m_busy = 0;
      m_err = 0;
      exp_addr_q.delete();
      exp_data_q.delete();
      m_out = 0;
      done_due = -1;
      held = 0;
      held_cnt = 0;
    end else begin
      check("busy", busy_o, m_busy);
      check("done", done_o, ncyc == done_due);
      check("err", err_o, m_err);
      check("we_be", {obi_we_o, obi_be_o}, {1'b0, 4'hF});

      exp_req = held || (m_busy && exp_addr_q.size() != 0 &&
                         m_out < int'(MO) && m_out < int'(fifo_free_i));
      check("obi_req", obi_req_o, exp_req);
      if (held) check("addr_stable", obi_addr_o, held_addr);
      if (obi_req_o) n_req_cycles++;

      if (obi_req_o && obi_gnt_i) begin
        exp_v = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hDEAD_BEEF;
        check("grant_addr", obi_addr_o, exp_v);
        if (!first_seen) begin
          first_addr = obi_addr_o;
          first_seen = 1;
        end
        hs_valid = 1;
        hs_addr  = obi_addr_o;
        hs_cyc   = ncyc;
        m_out++;
      end

      check("push", fifo_push_o, obi_rvalid_i);
      if (obi_rvalid_i) begin
        exp_v = (exp_data_q.size() != 0) ? exp_data_q.pop_front() : 32'hDEAD_BEEF;
        check("push_data", fifo_data_o, exp_v);
        m_out--;
        n_push++;
        rsp_left--;
        if (obi_err_i) m_err = 1;
        if (rsp_left == 0) done_due = ncyc + 2;
      end
      check("out_limit", (m_out <= out_limit) && (m_out >= 0), 1);

      if (done_o) begin
        n_done++;
        done_cyc = ncyc;
      end

      if (start_i && !m_busy) begin
        logic [31:0] base;
        base = src_addr_i & ~32'h3;
        m_busy = 1;
        m_err = 0;
        exp_addr_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < int'(len_i); i++) begin
          exp_addr_q.push_back(base + 32'(4 * i));
          exp_data_q.push_back(pattern(base + 32'(4 * i)));
        end
        rsp_left   = int'(len_i);
        n_push     = 0;
        n_done     = 0;
        max_held   = 0;
        first_seen = 0;
        start_cyc  = ncyc;
        if (len_i == '0) done_due = ncyc + 1;
      end else if (ncyc == done_due) begin
        m_busy = 0;
        done_due = -1;
      end

      held      = obi_req_o && !obi_gnt_i;
      held_addr = obi_addr_o;
      held_cnt  = held ? held_cnt + 1 : 0;
      if (held_cnt > max_held) max_held = held_cnt;
    end
  end

  task automatic do_start(input logic [31:0] addr, input int len);
    @(posedge clk);
    #1;
    rsp_idx    = 0;
    start_i    = 1'b1;
    src_addr_i = addr;
    len_i      = LenW'(len);
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (!m_busy && !busy_o) break;
    end
    check("idle_reached", {m_busy, busy_o}, 2'b00);
  endtask

  initial begin
    int snap;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    src_addr_i  = '0;
    len_i       = '0;
    fifo_free_i = FreeW'(4);

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req", obi_req_o, 0);
    check("rst_addr", obi_addr_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_push", fifo_push_o, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk);

    // Basic 4-word burst.
    do_start(32'h1000, 4);
    wait_idle();
    check("t1_pushes", n_push, 4);
    check("t1_done_pulses", n_done, 1);
    check("t1_first_addr", first_addr, 32'h1000);
    check("t1_busy_low", busy_o, 0);

    // Zero length: no bus traffic, done one cycle after start.
    snap = n_req_cycles;
    do_start(32'h1800, 0);
    wait_idle();
    check("t2_no_req", n_req_cycles - snap, 0);
    check("t2_done_lat", done_cyc - start_cyc, 1);

    // Unaligned source address.
    do_start(32'h2003, 2);
    wait_idle();
    check("t3_first_addr", first_addr, 32'h2000);
    check("t3_pushes", n_push, 2);

    // No FIFO space for 10 cycles, then a single slot.
    fifo_free_i = '0;
    snap = n_req_cycles;
    do_start(32'h2400, 3);
    repeat (10) @(posedge clk);
    check("t4_no_req_hold", n_req_cycles - snap, 0);
    #1;
    out_limit   = 1;
    fifo_free_i = FreeW'(1);
    wait_idle();
    check("t4_pushes", n_push, 3);
    out_limit   = MO;
    fifo_free_i = FreeW'(4);

    // Slow grant while FIFO space toggles.
    gnt_wait = 3;
    do_start(32'h3000, 3);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      fifo_free_i = (fifo_free_i == FreeW'(4)) ? '0 : FreeW'(4);
      if (!m_busy) break;
    end
    wait_idle();
    check("t5_max_stall", max_held, 3);
    check("t5_pushes", n_push, 3);
    gnt_wait    = 0;
    fifo_free_i = FreeW'(4);

    // Error on second response plus a dropped mid-transfer start.
    err_idx = 1;
    do_start(32'h3800, 3);
    @(posedge clk);
    #1;
    start_i    = 1'b1;
    src_addr_i = 32'h4000;
    len_i      = LenW'(5);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_idle();
    check("t6_pushes", n_push, 3);
    check("t6_err_sticky", err_o, 1);
    err_idx = -1;
    do_start(32'h5000, 1);
    @(negedge clk);
    #1;
    check("t6_err_cleared", err_o, 0);
    wait_idle();
    check("t6_pushes_after", n_push, 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
